// File: rtl/joy_pkg.sv
// Shared definitions for the joypad responder: FSM states, protocol
// constants, host-side register map and the reply-byte table.
package joy_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        ACK_WAIT = 3'd2,
        ACK_LOW  = 3'd3,
        IGNORE   = 3'd4
    } joy_state_e;

    // Protocol bytes
    localparam logic [7:0] REPLY_HDR = 8'hFF;
    localparam logic [7:0] PAD_ID_LO = 8'h41;
    localparam logic [7:0] PAD_ID_HI = 8'h5A;
    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_POLL  = 8'h42;

    // Byte positions within a poll
    localparam logic [2:0] BTN_LATCH_BYTE = 3'd2;
    localparam logic [2:0] LAST_BYTE      = 3'd4;

    // Register addresses shared with the host controller
    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_LAST_CMD = 8'h08;
    localparam logic [7:0] REG_BUTTONS  = 8'h0C;

    // Reply byte sent back to the host for a given byte index
    function automatic logic [7:0] reply_byte(input logic [2:0] idx, input logic [15:0] btn);
        logic [7:0] r;
        case (idx)
            3'd0:    r = REPLY_HDR;
            3'd1:    r = PAD_ID_LO;
            3'd2:    r = PAD_ID_HI;
            3'd3:    r = btn[7:0];
            3'd4:    r = btn[15:8];
            default: r = REPLY_HDR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/joy_sync2.sv
// Two-flop synchronizer for one asynchronous pad input; presets to 1 so
// idle-high lines look idle straight out of reset.
module joy_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/joy_pad_responder.sv
// Digital joypad responder: answers a 5-byte host poll over a serial
// clk/cmd/data link, pulsing /ACK after each accepted byte.
module joy_pad_responder
    import joy_pkg::*;
#(
    parameter int ACK_DELAY = 16,
    parameter int ACK_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        joy_clk,
    input  logic        joy_cmd,
    input  logic        joy_att,
    input  logic [15:0] buttons,
    output logic        joy_data,
    output logic        joy_ack,
    output logic [7:0]  last_cmd,
    output logic        xfer_done
);

    localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic jclk_s;
    logic jcmd_s;
    logic jatt_s;

    joy_sync2 u_sync_clk (.clk(clk), .rst(rst), .d_i(joy_clk), .q_o(jclk_s));
    joy_sync2 u_sync_cmd (.clk(clk), .rst(rst), .d_i(joy_cmd), .q_o(jcmd_s));
    joy_sync2 u_sync_att (.clk(clk), .rst(rst), .d_i(joy_att), .q_o(jatt_s));

    joy_state_e       state_q,    state_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             data_q,     data_d;
    logic             ack_q,      ack_d;
    logic             done_q,     done_d;
    logic [7:0]       last_cmd_q, last_cmd_d;
    logic [7:0]       rx_q,       rx_d;
    logic [7:0]       reply_q,    reply_d;
    logic [15:0]      btn_q,      btn_d;
    logic             jclk_prev_q;

    logic       jclk_fall;
    logic       jclk_rise;
    logic [7:0] rx_full;

    assign jclk_fall = jclk_prev_q & ~jclk_s;
    assign jclk_rise = ~jclk_prev_q & jclk_s;
    // LSB-first shift: after eight rising edges the first bit sits in bit 0
    assign rx_full   = {jcmd_s, rx_q[7:1]};

    // Next-state and output logic; deselect overrides everything else
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        ack_d      = ack_q;
        done_d     = 1'b0;
        last_cmd_d = last_cmd_q;
        rx_d       = rx_q;
        reply_d    = reply_q;
        btn_d      = btn_q;

        if (jatt_s) begin
            state_d    = IDLE;
            byte_idx_d = '0;
            bit_cnt_d  = '0;
            cnt_d      = '0;
            data_d     = 1'b1;
            ack_d      = 1'b1;
            rx_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = SHIFT;
                    byte_idx_d = '0;
                    bit_cnt_d  = '0;
                    rx_d       = '0;
                    reply_d    = reply_byte(3'd0, btn_q);
                end
                SHIFT: begin
                    if (jclk_fall) begin
                        data_d = reply_q[bit_cnt_q];
                    end else if (jclk_rise) begin
                        rx_d      = rx_full;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            last_cmd_d = rx_full;
                            cnt_d      = '0;
                            if (byte_idx_q == LAST_BYTE) begin
                                done_d  = 1'b1;
                                data_d  = 1'b1;
                                state_d = IGNORE;
                            end else if ((byte_idx_q == 3'd0 && rx_full != CMD_START) ||
                                         (byte_idx_q == 3'd1 && rx_full != CMD_POLL)) begin
                                data_d  = 1'b1;
                                state_d = IGNORE;
                            end else begin
                                if (byte_idx_q == BTN_LATCH_BYTE) begin
                                    btn_d = buttons;
                                end
                                state_d = ACK_WAIT;
                            end
                        end
                    end
                end
                ACK_WAIT: begin
                    if (cnt_q == CNT_W'(ACK_DELAY - 1)) begin
                        cnt_d   = '0;
                        ack_d   = 1'b0;
                        state_d = ACK_LOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ACK_LOW: begin
                    if (cnt_q == CNT_W'(ACK_WIDTH - 1)) begin
                        cnt_d      = '0;
                        ack_d      = 1'b1;
                        byte_idx_d = byte_idx_q + 3'd1;
                        reply_d    = reply_byte(byte_idx_q + 3'd1, btn_q);
                        state_d    = SHIFT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                IGNORE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control state and host-visible outputs, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            byte_idx_q  <= '0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            data_q      <= 1'b1;
            ack_q       <= 1'b1;
            done_q      <= 1'b0;
            last_cmd_q  <= '0;
            jclk_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            last_cmd_q  <= last_cmd_d;
            jclk_prev_q <= jclk_s;
        end
    end

    // Shift, reply and button holding registers; always reloaded before use
    always_ff @(posedge clk) begin
        rx_q    <= rx_d;
        reply_q <= reply_d;
        btn_q   <= btn_d;
    end

    assign joy_data  = data_q;
    assign joy_ack   = ack_q;
    assign last_cmd  = last_cmd_q;
    assign xfer_done = done_q;

endmodule

// File: tb/tb_joy_pad_responder.sv
// Host-side bench for joy_pad_responder: directed scenarios plus random
// polls checked against a protocol-level expectation model.
module tb_joy_pad_responder;

    localparam int ACK_DELAY = 16;
    localparam int ACK_WIDTH = 8;
    localparam int HALF      = 6;   // host half bit period in clk cycles
    localparam int SYNC_LAT  = 3;   // pin edge to registered reaction
    localparam int WIN       = ACK_DELAY + SYNC_LAT + ACK_WIDTH + 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        joy_clk;
    logic        joy_cmd;
    logic        joy_att;
    logic [15:0] buttons;
    logic        joy_data;
    logic        joy_ack;
    logic [7:0]  last_cmd;
    logic        xfer_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    joy_pad_responder #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
        .clk(clk), .rst(rst), .joy_clk(joy_clk), .joy_cmd(joy_cmd),
        .joy_att(joy_att), .buttons(buttons), .joy_data(joy_data),
        .joy_ack(joy_ack), .last_cmd(last_cmd), .xfer_done(xfer_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (xfer_done === 1'b1) done_seen++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full host byte; returns right after the 8th rising edge is driven
    task automatic xfer_byte(input logic [7:0] cmd, output logic [7:0] rsp,
                             input bit chg, input logic [15:0] bnew);
        rsp = '0;
        for (int b = 0; b < 8; b++) begin
            joy_clk = 1'b0;
            joy_cmd = cmd[b];
            if (chg && b == 3) buttons = bnew;
            repeat (HALF) @(negedge clk);
            rsp[b]  = joy_data;
            joy_clk = 1'b1;
            if (b != 7) repeat (HALF) @(negedge clk);
        end
    endtask

    // Bits 0..nbits-1 complete, then bit nbits driven low and held
    task automatic partial_byte(input logic [7:0] cmd, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            joy_clk = 1'b0;
            joy_cmd = cmd[b];
            repeat (HALF) @(negedge clk);
            joy_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        joy_clk = 1'b0;
        joy_cmd = cmd[nbits];
        repeat (HALF) @(negedge clk);
    endtask

    task automatic check_ack(input int idx, input bit exp);
        int first = -1;
        int low   = 0;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (joy_ack !== 1'b1) begin
                low++;
                if (first < 0) first = k;
            end
        end
        if (exp) begin
            chk_eq($sformatf("ack_start%0d", idx), first, ACK_DELAY + SYNC_LAT);
            chk_eq($sformatf("ack_width%0d", idx), low, ACK_WIDTH);
        end else begin
            chk_eq($sformatf("no_ack%0d", idx), low, 0);
        end
    endtask

    // Full poll; expectations derived from the protocol rules alone
    task automatic run_poll(input logic [7:0] c0, c1, c2, c3, c4,
                            input logic [15:0] b_init, b_mid, input bit extra);
        logic [7:0] cmd [5];
        logic [7:0] er  [5];
        bit         ea  [5];
        logic [7:0] el;
        logic [7:0] rsp;
        bit v0, v1;
        int ed, d0;
        cmd[0] = c0; cmd[1] = c1; cmd[2] = c2; cmd[3] = c3; cmd[4] = c4;
        v0 = (c0 == 8'h01);
        v1 = v0 && (c1 == 8'h42);
        er[0] = 8'hFF;
        er[1] = v0 ? 8'h41 : 8'hFF;
        er[2] = v1 ? 8'h5A : 8'hFF;
        er[3] = v1 ? b_init[7:0]  : 8'hFF;
        er[4] = v1 ? b_init[15:8] : 8'hFF;
        ea[0] = v0; ea[1] = v1; ea[2] = v1; ea[3] = v1; ea[4] = 1'b0;
        el = !v0 ? c0 : (!v1 ? c1 : c4);
        ed = v1 ? 1 : 0;

        buttons = b_init;
        d0 = done_seen;
        joy_att = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            xfer_byte(cmd[i], rsp, i == 3, b_mid);
            chk_eq($sformatf("reply%0d", i), rsp, er[i]);
            check_ack(i, ea[i]);
        end
        chk_eq("last_cmd", last_cmd, el);
        chk_eq("xfer_done", done_seen - d0, ed);
        if (extra) begin
            xfer_byte(8'h01, rsp, 1'b0, b_mid);
            chk_eq("held_att_reply", rsp, 8'hFF);
            check_ack(9, 1'b0);
            chk_eq("held_att_last", last_cmd, el);
            chk_eq("held_att_done", done_seen - d0, ed);
        end
        joy_att = 1'b1;
        repeat (5) @(negedge clk);
        chk_eq("idle_data", joy_data, 1'b1);
        chk_eq("idle_ack", joy_ack, 1'b1);
    endtask

    initial begin
        logic [7:0] rsp;
        int k;
        rst = 1'b0; joy_clk = 1'b1; joy_cmd = 1'b1; joy_att = 1'b1; buttons = 16'hFFFF;
        repeat (4) @(negedge clk);
        chk_eq("rst_data", joy_data, 1'b1);
        chk_eq("rst_ack", joy_ack, 1'b1);
        chk_eq("rst_last", last_cmd, 8'h00);
        chk_eq("rst_done", xfer_done, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Full poll, wrong address then recovery, wrong command, button latch
        run_poll(8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 16'hFFFE, 16'hFFFE, 1'b1);
        run_poll(8'h81, 8'h42, 8'h00, 8'h00, 8'h00, 16'h1234, 16'h1234, 1'b0);
        run_poll(8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 16'hA55A, 16'hA55A, 1'b0);
        run_poll(8'h01, 8'h43, 8'h00, 8'h00, 8'h00, 16'h0F0F, 16'h0F0F, 1'b0);
        run_poll(8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 16'hFFFE, 16'h0000, 1'b0);

        // Deselect during bit 4 of byte 3
        buttons = 16'h0000;
        joy_att = 1'b0;
        repeat (6) @(negedge clk);
        xfer_byte(8'h01, rsp, 1'b0, 16'h0000); check_ack(0, 1'b1);
        xfer_byte(8'h42, rsp, 1'b0, 16'h0000); check_ack(1, 1'b1);
        xfer_byte(8'h5C, rsp, 1'b0, 16'h0000); check_ack(2, 1'b1);
        partial_byte(8'hA5, 4);
        chk_eq("pre_abort_data", joy_data, 1'b0);
        joy_att = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("abort_bit_data", joy_data, 1'b1);
        chk_eq("abort_bit_ack", joy_ack, 1'b1);
        chk_eq("abort_bit_last", last_cmd, 8'h5C);
        joy_clk = 1'b1;
        repeat (5) @(negedge clk);
        run_poll(8'h01, 8'h42, 8'h11, 8'h22, 8'h33, 16'hBEEF, 16'hBEEF, 1'b0);

        // Deselect while /ACK is low
        joy_att = 1'b0;
        repeat (6) @(negedge clk);
        xfer_byte(8'h01, rsp, 1'b0, 16'hBEEF);
        chk_eq("abort_ack_reply", rsp, 8'hFF);
        k = 0;
        while (joy_ack === 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk_eq("abort_ack_seen", joy_ack, 1'b0);
        repeat (3) @(negedge clk);
        joy_att = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("abort_ack_ack", joy_ack, 1'b1);
        chk_eq("abort_ack_data", joy_data, 1'b1);
        k = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (joy_ack !== 1'b1) k++;
        end
        chk_eq("abort_ack_stays_high", k, 0);
        chk_eq("abort_ack_last", last_cmd, 8'h01);
        run_poll(8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 16'h7E81, 16'h7E81, 1'b0);

        // Reset during bit 5 of byte 1
        joy_att = 1'b0;
        repeat (6) @(negedge clk);
        xfer_byte(8'h01, rsp, 1'b0, 16'hFFFF); check_ack(0, 1'b1);
        partial_byte(8'h42, 5);
        chk_eq("pre_rst_data", joy_data, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("midrst_data", joy_data, 1'b1);
        chk_eq("midrst_ack", joy_ack, 1'b1);
        chk_eq("midrst_last", last_cmd, 8'h00);
        chk_eq("midrst_done", xfer_done, 1'b0);
        joy_att = 1'b1; joy_clk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        run_poll(8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 16'h3C3C, 16'h3C3C, 1'b0);

        // Random polls
        for (int n = 0; n < 20; n++) begin
            logic [7:0] r0, r1;
            r0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01;
            r1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h42;
            run_poll(r0, r1, 8'($urandom), 8'($urandom), 8'($urandom),
                     16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
